// File: rtl/ivector_rr.sv
// ivector_rr: message demultiplexer / round-robin arbiter.
// Each in_say beat is steered by its meth index into one of NCHAN
// circular FIFOs.  A round-robin arbiter drains the non-empty FIFOs
// onto out_heard and tags each beat with its channel index.  Beats whose
// index is out of range are dropped and counted (saturating).
//
// Ports:
//   CLK             clock, rising edge
//   nRST            asynchronous active-low reset
//   in_say__ENA     enqueue request (transfer on ENA & RDY)
//   in_say_meth     destination channel index (all 32 bits compared)
//   in_say_v        payload
//   in_say__RDY     acceptance: always 1 for out-of-range meth, else not-full
//   out_heard__ENA  beat valid (grant exists & consumer ready)
//   out_heard_meth  granted channel index, 0 when no grant
//   out_heard_v     head entry of the granted channel, 0 when no grant
//   out_heard__RDY  consumer ready
//   drop_count      saturating count of dropped beats
module ivector_rr #(
    parameter int NCHAN = 10,
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_say__ENA,
    input  logic [31:0]      in_say_meth,
    input  logic [WIDTH-1:0] in_say_v,
    output logic             in_say__RDY,
    output logic             out_heard__ENA,
    output logic [31:0]      out_heard_meth,
    output logic [WIDTH-1:0] out_heard_v,
    input  logic             out_heard__RDY,
    output logic [15:0]      drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(NCHAN);

    logic [WIDTH-1:0] mem_q  [NCHAN][DEPTH];
    logic [AW-1:0]    wptr_q [NCHAN];
    logic [AW-1:0]    wptr_d [NCHAN];
    logic [AW-1:0]    rptr_q [NCHAN];
    logic [AW-1:0]    rptr_d [NCHAN];
    logic [CW-1:0]    cnt_q  [NCHAN];
    logic [CW-1:0]    cnt_d  [NCHAN];
    logic [PW-1:0]    prio_q;
    logic [PW-1:0]    prio_d;
    logic [15:0]      drop_q;
    logic [15:0]      drop_d;

    logic             oob_s;
    logic [PW-1:0]    sel_s;
    logic             enq_s;
    logic             grant_vld_s;
    logic [PW-1:0]    grant_s;
    logic             deq_s;
    logic [PW:0]      sum_s  [NCHAN];
    logic [PW-1:0]    cand_s [NCHAN];
    logic [PW:0]      prio_sum_s;

    // Input decode: the full 32-bit index decides in/out of range.
    always_comb begin
        oob_s = (in_say_meth >= 32'(NCHAN));
        sel_s = in_say_meth[PW-1:0];
        if (oob_s) begin
            in_say__RDY = 1'b1;
        end else begin
            // Registered count only: a full channel stays not-ready even
            // when it is being drained this cycle.
            in_say__RDY = (cnt_q[sel_s] < CW'(DEPTH));
        end
        enq_s = in_say__ENA & in_say__RDY & ~oob_s;
    end

    // Round-robin search starting at prio; the lowest offset wins, so the
    // scan runs from the highest offset down and later hits overwrite.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = {PW{1'b0}};
        for (int i = 0; i < NCHAN; i++) begin
            sum_s[i] = {1'b0, prio_q} + (PW+1)'(i);
            if (sum_s[i] >= (PW+1)'(NCHAN)) begin
                cand_s[i] = PW'(sum_s[i] - (PW+1)'(NCHAN));
            end else begin
                cand_s[i] = PW'(sum_s[i]);
            end
        end
        for (int i = NCHAN - 1; i >= 0; i--) begin
            grant_vld_s = grant_vld_s | (cnt_q[cand_s[i]] != {CW{1'b0}});
            grant_s     = (cnt_q[cand_s[i]] != {CW{1'b0}}) ? cand_s[i] : grant_s;
        end
    end

    // Output port drive from registered state.
    always_comb begin
        deq_s          = grant_vld_s & out_heard__RDY;
        out_heard__ENA = deq_s;
        drop_count     = drop_q;
        if (grant_vld_s) begin
            out_heard_meth = 32'(grant_s);
            out_heard_v    = mem_q[grant_s][rptr_q[grant_s]];
        end else begin
            out_heard_meth = 32'd0;
            out_heard_v    = {WIDTH{1'b0}};
        end
    end

    // Next-state for per-channel pointers/counts, priority and drop counter.
    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            wptr_d[c] = wptr_q[c];
            rptr_d[c] = rptr_q[c];
            cnt_d[c]  = cnt_q[c];
            if (enq_s && (sel_s == PW'(c))) begin
                wptr_d[c] = wptr_q[c] + AW'(1'b1);
            end else begin
                wptr_d[c] = wptr_q[c];
            end
            if (deq_s && (grant_s == PW'(c))) begin
                rptr_d[c] = rptr_q[c] + AW'(1'b1);
            end else begin
                rptr_d[c] = rptr_q[c];
            end
            case ({enq_s && (sel_s == PW'(c)), deq_s && (grant_s == PW'(c))})
                2'b10:   cnt_d[c] = cnt_q[c] + CW'(1'b1);
                2'b01:   cnt_d[c] = cnt_q[c] - CW'(1'b1);
                default: cnt_d[c] = cnt_q[c];
            endcase
        end

        prio_sum_s = {1'b0, grant_s} + (PW+1)'(1'b1);
        if (deq_s) begin
            if (prio_sum_s >= (PW+1)'(NCHAN)) begin
                prio_d = {PW{1'b0}};
            end else begin
                prio_d = PW'(prio_sum_s);
            end
        end else begin
            prio_d = prio_q;
        end

        if (in_say__ENA && oob_s && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int c = 0; c < NCHAN; c++) begin
                wptr_q[c] <= {AW{1'b0}};
                rptr_q[c] <= {AW{1'b0}};
                cnt_q[c]  <= {CW{1'b0}};
            end
            prio_q <= {PW{1'b0}};
            drop_q <= 16'h0000;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            prio_q <= prio_d;
            drop_q <= drop_d;
        end
    end

    // FIFO storage write; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (enq_s) begin
            mem_q[sel_s][wptr_q[sel_s]] <= in_say_v;
        end
    end

endmodule

// File: tb/tb_ivector_rr.sv
// Self-checking bench for ivector_rr: directed scenarios plus randomized
// traffic, compared against a queue-based reference model.
module tb_ivector_rr;

    localparam int NCHAN = 10;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        say_ena = 1'b0;
    logic [31:0] say_meth = 32'd0;
    logic [31:0] say_v = 32'd0;
    logic        say_rdy;
    logic        h_ena;
    logic [31:0] h_meth;
    logic [31:0] h_v;
    logic        h_rdy = 1'b0;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ivector_rr #(.NCHAN(NCHAN), .DEPTH(DEPTH), .WIDTH(32)) dut (
        .CLK            (clk),
        .nRST           (nrst),
        .in_say__ENA    (say_ena),
        .in_say_meth    (say_meth),
        .in_say_v       (say_v),
        .in_say__RDY    (say_rdy),
        .out_heard__ENA (h_ena),
        .out_heard_meth (h_meth),
        .out_heard_v    (h_v),
        .out_heard__RDY (h_rdy),
        .drop_count     (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per channel, a priority index, a drop tally.
    logic [31:0] mq [NCHAN][$];
    int          m_prio = 0;
    int          m_drop = 0;
    bit          e_rdy, e_ena, e_found;
    int          e_grant;
    logic [31:0] e_meth, e_v;

    function automatic void model_reset();
        for (int c = 0; c < NCHAN; c++) mq[c].delete();
        m_prio = 0;
        m_drop = 0;
    endfunction

    function automatic void model_eval();
        if (!nrst) begin
            e_rdy = 1'b1;
        end else if (say_meth >= NCHAN) begin
            e_rdy = 1'b1;
        end else begin
            e_rdy = (mq[say_meth].size() < DEPTH);
        end
        e_found = 1'b0;
        e_grant = 0;
        for (int k = 0; k < NCHAN; k++) begin
            int c;
            c = (m_prio + k) % NCHAN;
            if (!e_found && mq[c].size() != 0) begin
                e_found = 1'b1;
                e_grant = c;
            end
        end
        e_ena  = e_found && h_rdy;
        e_meth = e_found ? 32'(e_grant) : 32'd0;
        e_v    = e_found ? mq[e_grant][0] : 32'd0;
    endfunction

    function automatic void model_commit();
        model_eval();
        if (say_ena) begin
            if (say_meth >= NCHAN) begin
                if (m_drop < 65535) m_drop++;
            end else if (e_rdy) begin
                mq[say_meth].push_back(say_v);
            end
        end
        if (e_ena) begin
            void'(mq[e_grant].pop_front());
            m_prio = (e_grant + 1) % NCHAN;
        end
    endfunction

    // Advance one clock; inputs are stable across the edge.
    task automatic cyc();
        @(posedge clk);
        if (!nrst) model_reset();
        else model_commit();
        #1;
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        model_reset();
        say_ena = 1'b0;
        cyc();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        say_meth = 32'd7;
        #2;
        n_cmp++;
        if ({say_rdy, h_ena, h_meth, h_v, drop_cnt} !== {1'b1, 1'b0, 32'd0, 32'd0, 16'd0}) begin
            n_bad++;
            $display("FAIL reset_idle got rdy=%b ena=%b meth=%h v=%h drop=%h", say_rdy, h_ena, h_meth, h_v, drop_cnt);
        end
        say_meth = 32'd99;
        #1;
        n_cmp++;
        if (say_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rdy_oob got=%b exp=1", say_rdy);
        end
        cyc();
        nrst = 1'b1;
        h_rdy = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            say_ena = 1'b1; say_meth = 32'(i); say_v = 32'(100 + i);
            cyc();
        end
        say_ena = 1'b0; say_meth = 32'd1; h_rdy = 1'b1;
        settle();
        n_cmp++;
        if ({h_ena, h_meth, h_v} !== {1'b1, 32'd1, 32'd101}) begin
            n_bad++;
            $display("FAIL reset_pre got ena=%b meth=%h v=%h exp 1/1/65", h_ena, h_meth, h_v);
        end
        nrst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({say_rdy, h_ena, h_meth, h_v, drop_cnt} !== {1'b1, 1'b0, 32'd0, 32'd0, 16'd0}) begin
            n_bad++;
            $display("FAIL reset_async got rdy=%b ena=%b meth=%h v=%h drop=%h", say_rdy, h_ena, h_meth, h_v, drop_cnt);
        end
        cyc();
        nrst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++;
            if ({say_rdy, h_ena} !== 2'b10) begin
                n_bad++;
                $display("FAIL reset_after got rdy=%b ena=%b exp rdy=1 ena=0", say_rdy, h_ena);
            end
            cyc();
        end
    endtask

    task automatic test_single();
        h_rdy = 1'b1;
        say_ena = 1'b1; say_meth = 32'd7; say_v = 32'hDEAD_BEEF;
        settle();
        n_cmp++;
        if (h_ena !== 1'b0) begin
            n_bad++;
            $display("FAIL single_nobypass got ena=%b exp=0", h_ena);
        end
        cyc();
        say_ena = 1'b0;
        settle();
        n_cmp++;
        if ({h_ena, h_meth, h_v} !== {1'b1, 32'd7, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL single_out got ena=%b meth=%h v=%h exp 1/7/deadbeef", h_ena, h_meth, h_v);
        end
        cyc();
        settle();
        n_cmp++;
        if (h_ena !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done got ena=%b exp=0", h_ena);
        end
    endtask

    task automatic test_full();
        h_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            say_ena = 1'b1; say_meth = 32'd2; say_v = 32'(i);
            cyc();
        end
        say_ena = 1'b0;
        settle();
        n_cmp++;
        if (say_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL full_rdy2 got=%b exp=0", say_rdy);
        end
        say_meth = 32'd3;
        settle();
        n_cmp++;
        if (say_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL full_rdy3 got=%b exp=1", say_rdy);
        end
        h_rdy = 1'b1;
        say_meth = 32'd2;
        for (int i = 1; i <= 4; i++) begin
            settle();
            n_cmp++;
            if ({h_ena, h_meth, h_v} !== {1'b1, 32'd2, 32'(i)}) begin
                n_bad++;
                $display("FAIL full_drain%0d got ena=%b meth=%h v=%h exp v=%0d", i, h_ena, h_meth, h_v, i);
            end
            if (i == 1) begin
                n_cmp++;
                if (say_rdy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_nobypass got rdy=%b exp=0", say_rdy);
                end
            end
            cyc();
        end
    endtask

    task automatic test_round_robin();
        int exp_seq [6] = '{0, 3, 9, 0, 3, 9};
        do_reset();
        h_rdy = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 3; j++) begin
                say_ena = 1'b1;
                say_meth = (j == 0) ? 32'd0 : ((j == 1) ? 32'd3 : 32'd9);
                say_v = $urandom;
                cyc();
            end
        end
        say_ena = 1'b0;
        h_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            n_cmp++;
            if ({h_ena, h_meth, h_v} !== {1'b1, 32'(exp_seq[i]), e_v}) begin
                n_bad++;
                $display("FAIL rr_%0d got ena=%b meth=%0d v=%h exp meth=%0d v=%h", i, h_ena, h_meth, h_v, exp_seq[i], e_v);
            end
            cyc();
        end
    endtask

    task automatic test_drop();
        logic [31:0] oob [3] = '{32'd10, 32'hFFFF_FFFF, 32'h8000_0003};
        h_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            say_ena = 1'b1; say_meth = oob[i]; say_v = $urandom;
            settle();
            n_cmp++;
            if ({say_rdy, h_ena} !== 2'b10) begin
                n_bad++;
                $display("FAIL drop_rdy%0d got rdy=%b ena=%b exp 1/0", i, say_rdy, h_ena);
            end
            cyc();
            if (i == 1) begin
                n_cmp++;
                if (drop_cnt !== 16'd2) begin
                    n_bad++;
                    $display("FAIL drop_two got=%0d exp=2", drop_cnt);
                end
            end
        end
        say_ena = 1'b0;
        settle();
        n_cmp++;
        if ({h_ena, drop_cnt} !== {1'b0, 16'd3}) begin
            n_bad++;
            $display("FAIL drop_three got ena=%b drop=%0d exp 0/3", h_ena, drop_cnt);
        end
        force dut.drop_q = 16'hFFFF;
        #1;
        release dut.drop_q;
        m_drop = 65535;
        say_ena = 1'b1; say_meth = 32'd12;
        #1;
        cyc();
        say_ena = 1'b0;
        settle();
        n_cmp++;
        if (drop_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL drop_sat got=%h exp=ffff", drop_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] sent [$];
        int got = 0;
        h_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            say_ena = (i < 11); say_meth = 32'd5; say_v = $urandom;
            if (i < 11) sent.push_back(say_v);
            settle();
            if (h_ena === 1'b1) begin
                n_cmp++;
                if ({h_meth, h_v} !== {32'd5, sent[0]}) begin
                    n_bad++;
                    $display("FAIL wrap_%0d got meth=%0d v=%h exp 5/%h", got, h_meth, h_v, sent[0]);
                end
                void'(sent.pop_front());
                got++;
            end
            cyc();
            n_cmp++;
            if (dut.cnt_q[5] > 1) begin
                n_bad++;
                $display("FAIL wrap_count got=%0d exp<=1", dut.cnt_q[5]);
            end
        end
        say_ena = 1'b0;
        n_cmp++;
        if (got != 11) begin
            n_bad++;
            $display("FAIL wrap_total got=%0d exp=11", got);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            say_ena = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       say_meth = 32'(NCHAN) + 32'($urandom_range(0, 5));
                1:       say_meth = $urandom | 32'h0001_0000;
                2, 3, 4: say_meth = 32'($urandom_range(0, 2));
                default: say_meth = 32'($urandom_range(0, NCHAN - 1));
            endcase
            say_v = $urandom;
            h_rdy = ($urandom_range(0, 3) != 0);
            settle();
            n_cmp++;
            if ({say_rdy, h_ena, h_meth, h_v, drop_cnt} !== {e_rdy, e_ena, e_meth, e_v, 16'(m_drop)}) begin
                n_bad++;
                $display("FAIL rand_%0d got rdy=%b ena=%b meth=%0d v=%h drop=%0d exp rdy=%b ena=%b meth=%0d v=%h drop=%0d",
                         i, say_rdy, h_ena, h_meth, h_v, drop_cnt, e_rdy, e_ena, e_meth, e_v, m_drop);
            end
            cyc();
        end
        say_ena = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_round_robin();
        test_drop();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
